// File: rtl/fsm_q6_pkg.sv
// rtl/fsm_q6_pkg.sv - shared state constants and one-hot check for the q6 sequencer
package fsm_q6_pkg;

   localparam int A = 1;
   localparam int B = 2;
   localparam int C = 3;
   localparam int D = 4;
   localparam int E = 5;
   localparam int F = 6;

   typedef enum logic [6:1] {
      S_A = 6'b000001,
      S_B = 6'b000010,
      S_C = 6'b000100,
      S_D = 6'b001000,
      S_E = 6'b010000,
      S_F = 6'b100000
   } q6_state_e;

   function automatic logic is_one_hot(input logic [6:1] v);
      return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
   endfunction

endpackage

// File: rtl/fsm_q6_sequencer_if.sv
// rtl/fsm_q6_sequencer_if.sv - sample handshake, preload and status bundle
interface fsm_q6_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             w_valid;
   logic             w;
   logic             w_ready;
   logic             load;
   logic [6:1]       load_state;
   logic             clr_illegal;
   logic [6:1]       state;
   logic             z;
   logic [CNT_W-1:0] run_len;
   logic             alarm;
   logic             illegal;

   modport master (
      output w_valid, w, load, load_state, clr_illegal,
      input  w_ready, state, z, run_len, alarm, illegal
   );

   modport slave (
      input  w_valid, w, load, load_state, clr_illegal,
      output w_ready, state, z, run_len, alarm, illegal
   );
endinterface

// File: rtl/fsm_q6_next.sv
// rtl/fsm_q6_next.sv - combinational one-hot next-state equations of the w-sequence FSM
module fsm_q6_next
   import fsm_q6_pkg::*;
(
   input  logic [6:1] y,
   input  logic       w,
   output logic [6:1] Y
);
   assign Y[A] = (y[A] | y[D]) & w;
   assign Y[B] = y[A] & ~w;
   assign Y[C] = (y[B] | y[F]) & ~w;
   assign Y[D] = (y[B] | y[C] | y[E] | y[F]) & w;
   assign Y[E] = (y[C] | y[E]) & ~w;
   assign Y[F] = y[D] & ~w;
endmodule

// File: rtl/fsm_q6_sequencer.sv
// rtl/fsm_q6_sequencer.sv - handshaked w-sequence FSM with preload, run-length alarm and illegal-state recovery
module fsm_q6_sequencer
   import fsm_q6_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int THRESH = 4
) (
   input logic               clk,
   input logic               resetn,
   fsm_q6_sequencer_if.slave bus
);
   localparam logic [CNT_W-1:0] RUN_MAX = '1;
   localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

   logic [6:1]       state_q, state_d, y_next;
   logic [CNT_W-1:0] run_q, run_d;
   logic             alarm_q, alarm_d;
   logic             illegal_q, illegal_d;
   logic             step;

   fsm_q6_next u_next (
      .y (state_q),
      .w (bus.w),
      .Y (y_next)
   );

   // load owns the cycle, so a concurrent sample is left for the producer to re-offer
   assign bus.w_ready = ~bus.load;
   assign step        = bus.w_valid & ~bus.load;

   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      alarm_d   = 1'b0;
      illegal_d = illegal_q & ~bus.clr_illegal;
      if (bus.load) begin
         run_d = '0;
         if (is_one_hot(bus.load_state)) begin
            state_d = bus.load_state;
         end else begin
            state_d   = S_A;
            illegal_d = 1'b1;
         end
      end else if (step) begin
         if (!is_one_hot(state_q)) begin
            state_d   = S_A;
            illegal_d = 1'b1;
            run_d     = '0;
         end else begin
            state_d = y_next;
            if (y_next[E] | y_next[F]) begin
               run_d = (run_q == RUN_MAX) ? run_q : run_q + CNT_W'(1);
            end else begin
               run_d = '0;
            end
            // saturation holds run_len still, which must not re-fire the alarm
            alarm_d = (run_d == THR) && (run_q != THR);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= S_A;
         run_q     <= '0;
         alarm_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         alarm_q   <= alarm_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.state   = state_q;
   assign bus.z       = state_q[E] | state_q[F];
   assign bus.run_len = run_q;
   assign bus.alarm   = alarm_q;
   assign bus.illegal = illegal_q;
endmodule
